// File: rtl/code_prefetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : code_prefetch_responder
// Description : Code-bus responder with a current word plus one sequential
//               prefetch entry, bridging a req/ack code memory to a fetch port.
// Revision    : 1.0 - initial release
// ============================================================================
module code_prefetch_responder #(
  parameter int PREFETCH_EN = 1,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  sysclk,
  input  logic                  sysreset,
  input  logic [ADDR_WIDTH-1:0] code_addr,
  output logic [DATA_WIDTH-1:0] code_in,
  output logic                  code_ready,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           miss_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEMAND   = 2'd1,
    ST_PREFETCH = 2'd2
  } state_t;

  localparam logic                  c_PF_EN    = (PREFETCH_EN != 0);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [15:0]           c_MISS_MAX = 16'hFFFF;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    r_cur_valid;
  logic [ADDR_WIDTH-1:0]   r_cur_addr;
  logic [DATA_WIDTH-1:0]   r_cur_data;
  logic                    r_nxt_valid;
  logic [ADDR_WIDTH-1:0]   r_nxt_addr;
  logic [DATA_WIDTH-1:0]   r_nxt_data;
  logic                    r_pf_pending;
  logic [ADDR_WIDTH-1:0]   r_pf_addr;
  logic                    r_mem_req;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [15:0]             r_miss_count;
  logic                    r_discard;

  logic                    w_hit_cur;
  logic                    w_hit_nxt;
  logic                    w_hit;
  logic                    w_promote;
  logic                    w_ack;
  logic                    w_write;
  logic                    w_pf_held;
  logic                    w_pf_cand_valid;
  logic [ADDR_WIDTH-1:0]   w_pf_cand_addr;
  logic                    w_issue_demand;
  logic                    w_issue_pf;

  assign w_hit_cur = r_cur_valid && (r_cur_addr == code_addr);
  assign w_hit_nxt = r_nxt_valid && (r_nxt_addr == code_addr);
  assign w_hit     = w_hit_cur || w_hit_nxt;
  assign w_promote = w_hit_nxt && !w_hit_cur && !flush;
  assign w_ack     = r_mem_req && mem_ack;
  // Data of a flushed or discarded request is never written.
  assign w_write   = w_ack && !r_discard && !flush;
  assign w_pf_held = (r_cur_valid && (r_cur_addr == r_pf_addr)) ||
                     (r_nxt_valid && (r_nxt_addr == r_pf_addr));

  assign code_ready = w_hit;
  assign code_in    = w_hit_cur ? r_cur_data :
                      w_hit_nxt ? r_nxt_data : '0;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign miss_count = r_miss_count;

  // A promotion offers its follow-on address straight away, so sequential
  // code does not fall into a demand miss while the queue is being loaded.
  always_comb begin
    w_pf_cand_addr  = r_pf_addr;
    w_pf_cand_valid = 1'b0;
    if (flush) begin
      w_pf_cand_valid = 1'b0;
    end else if (w_promote) begin
      w_pf_cand_addr  = r_nxt_addr + c_ADDR_ONE;
      w_pf_cand_valid = c_PF_EN;
    end else begin
      w_pf_cand_valid = r_pf_pending && !w_pf_held;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_issue_demand = 1'b0;
    w_issue_pf     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_hit && !flush) begin
          w_state_nxt    = ST_DEMAND;
          w_issue_demand = 1'b1;
        end else if (w_pf_cand_valid) begin
          w_state_nxt = ST_PREFETCH;
          w_issue_pf  = 1'b1;
        end
      end
      ST_DEMAND, ST_PREFETCH: begin
        if (w_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      r_cur_valid  <= 1'b0;
      r_cur_addr   <= '0;
      r_cur_data   <= '0;
      r_nxt_valid  <= 1'b0;
      r_nxt_addr   <= '0;
      r_nxt_data   <= '0;
      r_pf_pending <= 1'b0;
      r_pf_addr    <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_miss_count <= '0;
      r_discard    <= 1'b0;
    end else begin
      if (w_promote) begin
        r_cur_addr  <= r_nxt_addr;
        r_cur_data  <= r_nxt_data;
        r_cur_valid <= 1'b1;
        r_nxt_valid <= 1'b0;
      end
      // Fills land after promotion so a same-edge ack takes precedence.
      if (w_write && (r_state == ST_DEMAND)) begin
        r_cur_addr  <= r_mem_addr;
        r_cur_data  <= mem_rdata;
        r_cur_valid <= 1'b1;
        r_nxt_valid <= 1'b0;
      end
      if (w_write && (r_state == ST_PREFETCH)) begin
        r_nxt_addr  <= r_mem_addr;
        r_nxt_data  <= mem_rdata;
        r_nxt_valid <= 1'b1;
      end
      if (flush) begin
        r_cur_valid <= 1'b0;
        r_nxt_valid <= 1'b0;
      end

      if (flush) begin
        r_pf_pending <= 1'b0;
      end else if (w_write && (r_state == ST_DEMAND)) begin
        r_pf_pending <= c_PF_EN;
        r_pf_addr    <= r_mem_addr + c_ADDR_ONE;
      end else if (w_promote && c_PF_EN && (r_state != ST_IDLE)) begin
        r_pf_pending <= 1'b1;
        r_pf_addr    <= r_nxt_addr + c_ADDR_ONE;
      end else if ((r_state == ST_IDLE) && !w_issue_demand) begin
        r_pf_pending <= 1'b0;
      end

      if (w_issue_demand) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= code_addr;
      end else if (w_issue_pf) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= w_pf_cand_addr;
      end else if (w_ack) begin
        r_mem_req <= 1'b0;
      end

      if (w_issue_demand && (r_miss_count != c_MISS_MAX)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end

      if (w_ack) begin
        r_discard <= 1'b0;
      end else if (flush && r_mem_req) begin
        r_discard <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_code_prefetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_prefetch_responder
// Description : Directed bench for code_prefetch_responder with a latency-
//               programmable memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_prefetch_responder;

  logic        sysclk = 1'b0;
  logic        sysreset;
  logic [15:0] code_addr;
  logic [15:0] code_in;
  logic        code_ready;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 0;
  int rsp_cnt  = 0;
  bit auto_ack = 1'b1;
  bit late_ack = 1'b0;

  typedef struct {
    logic [15:0] addr;
    logic        flush;
    logic        ready;
    logic [15:0] code;
    logic        req;
    logic [15:0] maddr;
    logic [15:0] miss;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];

  always #5 sysclk = ~sysclk;

  code_prefetch_responder #(
    .PREFETCH_EN (1),
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (16)
  ) dut (
    .sysclk     (sysclk),
    .sysreset   (sysreset),
    .code_addr  (code_addr),
    .code_in    (code_in),
    .code_ready (code_ready),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .miss_count (miss_count)
  );

  function automatic logic [15:0] img(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AC3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks mem_lat cycles after it first sees mem_req.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge sysclk);
      if (!auto_ack) begin
        mem_ack   = late_ack;
        mem_rdata = 16'hDEAD;
        rsp_cnt   = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        rsp_cnt = 0;
      end else if (mem_req === 1'b1) begin
        if (rsp_cnt >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = img(mem_addr);
        end else begin
          rsp_cnt++;
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  task automatic rst_assert();
    sysreset = 1'b1;
    flush    = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
  endtask

  task automatic release_rst();
    @(posedge sysclk);
    #1 sysreset = 1'b0;
    #6;
  endtask

  task automatic tick();
    @(posedge sysclk);
    #7;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [15:0] a;
    bit done;

    sysreset  = 1'b1;
    flush     = 1'b0;
    code_addr = 16'h0010;

    tv[0]  = '{16'h0010, 1'b0, 1'b0, 16'h0000,      1'b0, 16'h0000, 16'd0};
    tv[1]  = '{16'h0010, 1'b0, 1'b0, 16'h0000,      1'b1, 16'h0010, 16'd1};
    tv[2]  = '{16'h0010, 1'b0, 1'b0, 16'h0000,      1'b1, 16'h0010, 16'd1};
    tv[3]  = '{16'h0010, 1'b0, 1'b0, 16'h0000,      1'b1, 16'h0010, 16'd1};
    tv[4]  = '{16'h0010, 1'b0, 1'b1, img(16'h0010), 1'b0, 16'h0010, 16'd1};
    tv[5]  = '{16'h0010, 1'b0, 1'b1, img(16'h0010), 1'b1, 16'h0011, 16'd1};
    tv[6]  = '{16'h0010, 1'b0, 1'b1, img(16'h0010), 1'b1, 16'h0011, 16'd1};
    tv[7]  = '{16'h0010, 1'b0, 1'b1, img(16'h0010), 1'b1, 16'h0011, 16'd1};
    tv[8]  = '{16'h0011, 1'b0, 1'b1, img(16'h0011), 1'b0, 16'h0011, 16'd1};
    tv[9]  = '{16'h0011, 1'b0, 1'b1, img(16'h0011), 1'b1, 16'h0012, 16'd1};
    tv[10] = '{16'h0012, 1'b0, 1'b0, 16'h0000,      1'b1, 16'h0012, 16'd1};
    tv[11] = '{16'h0012, 1'b0, 1'b0, 16'h0000,      1'b1, 16'h0012, 16'd1};
    tv[12] = '{16'h0012, 1'b0, 1'b1, img(16'h0012), 1'b0, 16'h0012, 16'd1};
    tv[13] = '{16'h0012, 1'b1, 1'b1, img(16'h0012), 1'b1, 16'h0013, 16'd1};
    tv[14] = '{16'h0012, 1'b0, 1'b0, 16'h0000,      1'b1, 16'h0013, 16'd1};
    tv[15] = '{16'h0012, 1'b0, 1'b0, 16'h0000,      1'b1, 16'h0013, 16'd1};
    tv[16] = '{16'h0012, 1'b0, 1'b0, 16'h0000,      1'b0, 16'h0013, 16'd1};
    tv[17] = '{16'h0012, 1'b0, 1'b0, 16'h0000,      1'b1, 16'h0012, 16'd2};

    // Test 1 plus promotion and flush-during-prefetch, cycle by cycle, L=2.
    mem_lat = 2;
    rst_assert();
    for (int i = 0; i < NV; i++) begin
      @(posedge sysclk);
      #1;
      sysreset  = 1'b0;
      code_addr = tv[i].addr;
      flush     = tv[i].flush;
      #6;
      chk($sformatf("v%0d_ready", i), code_ready, tv[i].ready);
      chk($sformatf("v%0d_code", i),  code_in,    tv[i].code);
      chk($sformatf("v%0d_req", i),   mem_req,    tv[i].req);
      chk($sformatf("v%0d_maddr", i), mem_addr,   tv[i].maddr);
      chk($sformatf("v%0d_miss", i),  miss_count, tv[i].miss);
    end
    flush = 1'b0;

    // Test 2: sequential run with L=0, initiator steps on each ready.
    mem_lat   = 0;
    code_addr = 16'h0010;
    rst_assert();
    a    = 16'h0010;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge sysclk);
      #1;
      sysreset  = 1'b0;
      code_addr = a;
      #6;
      if (code_ready) begin
        chk($sformatf("t2_code_%h", a), code_in, img(a));
        if (a == 16'h0020) done = 1'b1;
        else a = a + 16'd1;
      end
    end
    chk("t2_done", done, 1'b1);
    chk("t2_miss", miss_count, 16'd1);

    // Test 3: jump while prefetch of 0x0011 is outstanding, L=3.
    mem_lat   = 3;
    code_addr = 16'h0010;
    rst_assert();
    release_rst();
    n = 0;
    while (!(mem_req && mem_addr == 16'h0011) && n < 40) begin tick(); n++; end
    chk("t3_pf_issued", n < 40, 1'b1);
    @(posedge sysclk);
    #1 code_addr = 16'h0100;
    #6;
    n = 0;
    while (!mem_ack && n < 10) begin tick(); n++; end
    chk("t3_pf_ack_seen", n < 10, 1'b1);
    chk("t3_ack_addr", mem_addr, 16'h0011);
    chk("t3_miss_pre", miss_count, 16'd1);
    tick();
    chk("t3_gap_req", mem_req, 1'b0);
    tick();
    chk("t3_dem_req", mem_req, 1'b1);
    chk("t3_dem_addr", mem_addr, 16'h0100);
    chk("t3_miss", miss_count, 16'd2);
    n = 0;
    while (!code_ready && n < 10) begin tick(); n++; end
    chk("t3_ready", code_ready, 1'b1);
    chk("t3_code", code_in, img(16'h0100));

    // Test 4: flush mid-demand discards the fill.
    mem_lat   = 3;
    code_addr = 16'h0200;
    rst_assert();
    release_rst();
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    chk("t4_req", mem_req, 1'b1);
    chk("t4_miss1", miss_count, 16'd1);
    @(posedge sysclk);
    #1 flush = 1'b1;
    #6;
    @(posedge sysclk);
    #1 flush = 1'b0;
    #6;
    n = 0;
    while (!mem_ack && n < 10) begin tick(); n++; end
    chk("t4_ack_seen", mem_ack, 1'b1);
    chk("t4_ready_at_ack", code_ready, 1'b0);
    tick();
    chk("t4_ready_after", code_ready, 1'b0);
    chk("t4_req_after", mem_req, 1'b0);
    tick();
    chk("t4_rereq", mem_req, 1'b1);
    chk("t4_rereq_addr", mem_addr, 16'h0200);
    chk("t4_miss2", miss_count, 16'd2);
    n = 0;
    while (!code_ready && n < 10) begin tick(); n++; end
    chk("t4_ready", code_ready, 1'b1);
    chk("t4_code", code_in, img(16'h0200));

    // Test 5: prefetch wraps from 0xFFFF to 0x0000.
    mem_lat   = 1;
    code_addr = 16'hFFFF;
    rst_assert();
    release_rst();
    n = 0;
    while (!code_ready && n < 10) begin tick(); n++; end
    chk("t5_ready", code_ready, 1'b1);
    chk("t5_code", code_in, img(16'hFFFF));
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    chk("t5_pf_req", mem_req, 1'b1);
    chk("t5_pf_addr", mem_addr, 16'h0000);
    n = 0;
    while (mem_req && n < 10) begin tick(); n++; end
    chk("t5_pf_done", mem_req, 1'b0);
    @(posedge sysclk);
    #1 code_addr = 16'h0000;
    #6;
    chk("t5_wrap_ready", code_ready, 1'b1);
    chk("t5_wrap_code", code_in, img(16'h0000));
    chk("t5_miss", miss_count, 16'd1);

    // Test 6: reset while a request is outstanding; late ack ignored.
    auto_ack  = 1'b0;
    code_addr = 16'h0300;
    rst_assert();
    release_rst();
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    chk("t6_req", mem_req, 1'b1);
    chk("t6_miss1", miss_count, 16'd1);
    @(posedge sysclk);
    #1 sysreset = 1'b1;
    #6;
    @(posedge sysclk);
    #1;
    sysreset = 1'b0;
    late_ack = 1'b1;
    #6;
    chk("t6_req_cleared", mem_req, 1'b0);
    chk("t6_ready_cleared", code_ready, 1'b0);
    chk("t6_miss_cleared", miss_count, 16'd0);
    @(posedge sysclk);
    #1 late_ack = 1'b0;
    #6;
    chk("t6_ready_no_fill", code_ready, 1'b0);
    chk("t6_new_req", mem_req, 1'b1);
    chk("t6_new_addr", mem_addr, 16'h0300);
    chk("t6_miss_new", miss_count, 16'd1);
    tick();
    chk("t6_ready_still0", code_ready, 1'b0);
    auto_ack = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
